i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (responder) that lets an external host MCU read and write an 8-bit-addressed register space inside the controller over a standard two-wire bus. It is the responder-side counterpart of the on-chip I2C initiator used for PMIC control. It runs in the 33 MHz system clock domain and oversamples SCL/SDA; it contains no clock-stretching logic. It exposes a simple strobe-based register port to the control/CSR logic.

## Interface
Parameters:
- I2C_ADDR, 7'h3C: 7-bit target address this block ACKs.
- FILT_LEN, 3: glitch-filter length in clk cycles; a line change must be stable this long to be accepted.

Ports:
- clk  in  1  system clock, 33 MHz.
- rst  in  1  reset, asynchronous, active-high.
- i2c_scl  in  1  bus clock, input only.
- i2c_sda  inout  1  bus data, open-drain: driven 1'b0 or 1'bz only.
- reg_addr  out  8  register address for the current access.
- reg_wdata  out  8  write data, valid when reg_we=1.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read-fetch strobe.
- reg_rdata  in  8  read data, sampled exactly 1 clk after reg_re.
- busy  out  1  high from an accepted address match until STOP or START.
- dbg_state  out  4  current FSM state encoding.

## Operation
- Input conditioning: 2-flop synchronizer, then FILT_LEN-cycle stability filter, then edge detect on SCL and SDA.
- START: filtered SDA falls while SCL=1. STOP: filtered SDA rises while SCL=1.
- Bits are sampled on the filtered SCL rising edge, MSB first. SDA is changed only on the filtered SCL falling edge.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits {addr, rw}.
  - ADDR_ACK: on a match, ACK and set busy. rw=0 goes to SUB. rw=1 pulses reg_re and goes to READ. On a mismatch, go to IGNORE with SDA released.
  - SUB: shift 8 bits into reg_addr, then SUB_ACK (ACK), then WRITE.
  - WRITE: shift 8 bits, then WR_ACK. WR_ACK drives ACK, pulses reg_we with reg_wdata, increments reg_addr, and returns to WRITE.
  - READ: shift out the byte latched from reg_rdata, then RD_ACK (SDA released; sample the master's bit). If the master ACKs, increment reg_addr, pulse reg_re, and return to READ. If it NACKs, go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- reg_addr is 8 bits and wraps 0xFF→0x00 on auto-increment.
- The reg_re for the next read byte is issued at least 8 clk before that byte's first SCL falling edge.
- START in any state (repeated start) goes to ADDR, clears the bit counter and releases SDA. reg_addr is retained, so write-subaddress/repeated-start/read works.
- STOP in any state goes to IDLE, releases SDA and clears busy.
- A START/STOP and an SCL edge in the same cycle: START/STOP wins.
- Reset values: SDA released (z), reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state=IDLE. Asserting rst mid-transfer releases SDA immediately (asynchronously).

## Timing
- Filtered-edge latency: 2 (sync) + FILT_LEN clk from the pin edge, i.e. 5 clk ≈ 150 ns by default.
- Supports SCL up to 400 kHz, which gives at least 40 clk per SCL phase.
- ACK/data drive is applied 1 clk after the filtered SCL fall, giving ≥ 180 ns SDA hold after the pin fall.
- ACK/data drive is released 1 clk after the filtered SCL fall ending the ACK/bit slot.
- reg_we is asserted 1 clk after the filtered SCL fall that ends the 8th data bit. It is high for exactly 1 clk.
- reg_rdata is sampled 1 clk after reg_re. The requester's read path must be combinational or 1-cycle registered.

## Structure
- Shared header i2c_defs.vh holds:
  - FSM state localparams (4-bit);
  - the ACK/NACK level constants;
  - the default I2C_ADDR constant.
- The initiator uses the same header.
- One sub-module, i2c_line_filter: synchronizer + glitch filter + rise/fall detect for a single line. It is instantiated twice (SCL, SDA).

## Test plan
- Write 0x3C/W, sub 0x10, data 0xA5, STOP → ACK on all 3 bytes; one reg_we pulse with reg_addr=0x10, reg_wdata=0xA5; busy drops after STOP.
- Write sub 0xFE, data 0x11, 0x22, 0x33 → reg_we at addresses 0xFE, 0xFF, 0x00 (wrap); final reg_addr=0x01.
- Write sub 0x20, repeated START, 0x3C/R, read 2 bytes (ACK, then NACK) with reg_rdata=addr^0xFF → SDA returns 0xDF then 0xDE; reg_re at 0x20 and 0x21; SDA released after the NACK.
- Address 0x48 → NACK (SDA stays high); no reg_we/reg_re; busy=0; the next START to 0x3C is ACKed.
- 2-clk SDA glitch while SCL=1 → no START/STOP detected and the state is unchanged; rst pulse mid-byte → SDA=z within the same cycle, state=IDLE, all outputs at reset values.

Source files
------------

// File: rtl/i2c_target_regs_pkg.sv
// i2c_target_regs_pkg: shared I2C definitions for the target and initiator.
//   - FSM state encodings (4-bit, also exported on dbg_state)
//   - ACK/NACK bus levels
//   - default 7-bit target address
//   - line indices for the conditioned SCL/SDA vector
package i2c_target_regs_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_SUB      = 4'd3;
  localparam logic [3:0] ST_SUB_ACK  = 4'd4;
  localparam logic [3:0] ST_WRITE    = 4'd5;
  localparam logic [3:0] ST_WR_ACK   = 4'd6;
  localparam logic [3:0] ST_READ     = 4'd7;
  localparam logic [3:0] ST_RD_ACK   = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_ADDR_DFLT = 7'h3C;

  localparam int NUM_LINES = 2;
  localparam int LN_SDA    = 0;
  localparam int LN_SCL    = 1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: conditioning for one I2C line.
//   2-flop synchronizer, then a stability filter (the synchronized value must
//   differ from the accepted level for FILT_LEN consecutive clk before it is
//   taken), then rise/fall pulses aligned with the accepted-level update.
// Ports:
//   clk, rst   system clock, async active-high reset
//   line       raw pin
//   lvl        filtered level (resets to 1 = idle bus)
//   rise/fall  one-clk pulses in the cycle lvl changes
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        // FILT_LEN-th consecutive differing sample: accept it
        lvl  <= sync[1];
        rise <= sync[1];
        fall <= ~sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing an 8-bit-addressed register port.
//   Write: S {addr,W} A sub A data A data A ... P  (reg_addr auto-increments)
//   Read : S {addr,R} A data A data N P            (reg_re per byte)
//   Repeated START keeps reg_addr, so sub-write / Sr / read works.
// Ports:
//   clk, rst        33 MHz system clock, async active-high reset
//   i2c_scl         bus clock (input only, no stretching)
//   i2c_sda         open-drain data (0 or z)
//   reg_addr        current register address
//   reg_wdata       write data, valid with reg_we
//   reg_we, reg_re  one-clk write / read-fetch strobes
//   reg_rdata       read data, sampled 1 clk after reg_re
//   busy            address matched, until STOP/START
//   dbg_state       FSM state
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = I2C_ADDR_DFLT,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [3:0] dbg_state
);

  logic [NUM_LINES-1:0] pin, lvl, rise, fall;

  assign pin[LN_SCL] = i2c_scl;
  assign pin[LN_SDA] = i2c_sda;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_filt
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk  (clk),
      .rst  (rst),
      .line (pin[g]),
      .lvl  (lvl[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  logic scl_rise, scl_fall, sda_lvl, start, stop;
  assign scl_rise = rise[LN_SCL];
  assign scl_fall = fall[LN_SCL];
  assign sda_lvl  = lvl[LN_SDA];
  assign start    = fall[LN_SDA] & lvl[LN_SCL];
  assign stop     = rise[LN_SDA] & lvl[LN_SCL];

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] sh;       // rx shift in, tx shift out
  logic [7:0] rd_byte;  // fetched read data for the next byte
  logic       sda_oe;
  logic       mack;     // master ACKed the last read byte
  logic       re_q;

  // sda_oe is a flop with async reset, so rst releases the bus at once
  assign i2c_sda   = sda_oe ? I2C_ACK : 1'bz;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      rd_byte   <= '0;
      sda_oe    <= 1'b0;
      mack      <= 1'b0;
      re_q      <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_q   <= reg_re;
      if (re_q) rd_byte <= reg_rdata;

      // bus conditions take priority over any SCL edge in the same cycle
      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_SUB, ST_WRITE: begin
            if (scl_rise) begin
              sh      <= {sh[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              case (state)
                ST_ADDR: begin
                  if (sh[7:1] == I2C_ADDR) begin
                    state  <= ST_ADDR_ACK;
                    sda_oe <= 1'b1;
                    busy   <= 1'b1;
                    // fetch the first read byte a full SCL phase early
                    reg_re <= sh[0];
                  end else begin
                    state <= ST_IGNORE;
                  end
                end
                ST_SUB: begin
                  reg_addr <= sh;
                  sda_oe   <= 1'b1;
                  state    <= ST_SUB_ACK;
                end
                default: begin
                  reg_wdata <= sh;
                  reg_we    <= 1'b1;
                  sda_oe    <= 1'b1;
                  state     <= ST_WR_ACK;
                end
              endcase
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (sh[0]) begin
                state  <= ST_READ;
                sda_oe <= ~rd_byte[7];
                sh     <= {rd_byte[6:0], 1'b0};
              end else begin
                state  <= ST_SUB;
                sda_oe <= 1'b0;
              end
            end
          end
          ST_SUB_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= ST_WRITE;
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe   <= 1'b0;
              reg_addr <= reg_addr + 8'd1;
              state    <= ST_WRITE;
            end
          end
          ST_READ: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe <= ~sh[7];
                sh     <= {sh[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              mack <= (sda_lvl == I2C_ACK);
              // next fetch happens at the ACK rise, long before the byte starts
              if (sda_lvl == I2C_ACK) begin
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= 1'b1;
              end
            end else if (scl_fall) begin
              if (mack) begin
                state  <= ST_READ;
                sda_oe <= ~rd_byte[7];
                sh     <= {rd_byte[6:0], 1'b0};
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          default: ;  // IDLE, IGNORE: only START/STOP matter
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level bench for i2c_target_regs.
//   A bit-banged master drives SCL/SDA; expected register strobes are queued
//   as stimulus is issued and popped by a monitor when the DUT strobes.
module tb_i2c_target_regs;
  import i2c_target_regs_pkg::*;

  localparam int Q = 20;  // quarter SCL period in clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;
  logic [3:0] dbg_state;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  // requester read path: combinational
  assign reg_rdata = reg_addr ^ 8'hFF;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_scl   (m_scl),
    .i2c_sda   (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] we_q[$];
  logic [7:0]  re_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // strobe monitor / scoreboard
  logic we_prev = 1'b0;
  logic re_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) begin
        chk("we_width", we_prev, 0);
        chk("we_pending", we_q.size() != 0, 1);
        if (we_q.size() != 0) chk("we_addr_data", {reg_addr, reg_wdata}, we_q.pop_front());
      end
      if (reg_re) begin
        chk("re_width", re_prev, 0);
        chk("re_pending", re_q.size() != 0, 1);
        if (re_q.size() != 0) chk("re_addr", reg_addr, re_q.pop_front());
      end
    end
    we_prev <= reg_we;
    re_prev <= reg_re;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (!m_scl) begin  // repeated start
      m_low = 1'b0; clks(Q);
      m_scl = 1'b1; clks(2*Q);
    end
    m_low = 1'b1; clks(2*Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; clks(Q);
    m_scl = 1'b1; clks(2*Q);
    m_low = 1'b0; clks(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; clks(Q);
      m_scl = 1'b1;  clks(2*Q);
      m_scl = 1'b0;  clks(Q);
    end
  endtask

  task automatic get_ack(output logic a);
    m_low = 1'b0; clks(Q);
    m_scl = 1'b1; clks(Q);
    a = sda;      clks(Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic m_wr(input logic [7:0] b, output logic a);
    send_bits(b);
    get_ack(a);
  endtask

  // ack=1: master ACKs the byte; ack=0: NACK
  task automatic m_rd(input logic ack, output logic [7:0] b);
    b = '0;
    m_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clks(Q);
      m_scl = 1'b1; clks(Q);
      b = {b[6:0], sda}; clks(Q);
      m_scl = 1'b0; clks(Q);
    end
    m_low = ack; clks(Q);
    m_scl = 1'b1; clks(2*Q);
    m_scl = 1'b0; clks(Q);
    m_low = 1'b0;
  endtask

  logic       a;
  logic [7:0] rb;

  initial begin
    clks(5);
    chk("rst_sda", sda, 1);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    clks(10);

    // single write
    we_q.push_back({8'h10, 8'hA5});
    bus_start();
    m_wr(8'h78, a); chk("t1_addr_ack", a, I2C_ACK);
    chk("t1_busy", busy, 1);
    m_wr(8'h10, a); chk("t1_sub_ack", a, I2C_ACK);
    m_wr(8'hA5, a); chk("t1_data_ack", a, I2C_ACK);
    bus_stop(); clks(10);
    chk("t1_busy_stop", busy, 0);
    chk("t1_state", dbg_state, ST_IDLE);

    // burst write across the address wrap
    we_q.push_back({8'hFE, 8'h11});
    we_q.push_back({8'hFF, 8'h22});
    we_q.push_back({8'h00, 8'h33});
    bus_start();
    m_wr(8'h78, a); chk("t2_addr_ack", a, I2C_ACK);
    m_wr(8'hFE, a); chk("t2_sub_ack", a, I2C_ACK);
    m_wr(8'h11, a); chk("t2_d0_ack", a, I2C_ACK);
    m_wr(8'h22, a); chk("t2_d1_ack", a, I2C_ACK);
    m_wr(8'h33, a); chk("t2_d2_ack", a, I2C_ACK);
    bus_stop(); clks(10);
    chk("t2_final_addr", reg_addr, 8'h01);

    // sub write, repeated start, 2-byte read
    re_q.push_back(8'h20);
    re_q.push_back(8'h21);
    bus_start();
    m_wr(8'h78, a); chk("t3_addr_ack", a, I2C_ACK);
    m_wr(8'h20, a); chk("t3_sub_ack", a, I2C_ACK);
    bus_start();
    m_wr(8'h79, a); chk("t3_raddr_ack", a, I2C_ACK);
    m_rd(1'b1, rb); chk("t3_rd0", rb, 8'hDF);
    m_rd(1'b0, rb); chk("t3_rd1", rb, 8'hDE);
    clks(10);
    chk("t3_nack_release", sda, 1);
    chk("t3_state_ignore", dbg_state, ST_IGNORE);
    bus_stop(); clks(10);

    // foreign address ignored, then own address ACKed
    bus_start();
    m_wr(8'h90, a); chk("t4_addr_nack", a, I2C_NACK);
    chk("t4_busy", busy, 0);
    m_wr(8'h10, a); chk("t4_data_nack", a, I2C_NACK);
    bus_stop();
    bus_start();
    m_wr(8'h78, a); chk("t4_addr_ack", a, I2C_ACK);
    bus_stop(); clks(10);

    // 2-clk SDA glitches while SCL high
    bus_start();
    m_wr(8'h78, a); chk("t5_addr_ack", a, I2C_ACK);
    m_low = 1'b0; clks(Q);
    m_scl = 1'b1; clks(Q);
    m_low = 1'b1; clks(2);
    m_low = 1'b0; clks(Q);
    chk("t5_glitch_start_state", dbg_state, ST_SUB);
    chk("t5_glitch_start_busy", busy, 1);
    m_scl = 1'b0; clks(Q);
    m_low = 1'b1; clks(Q);
    m_scl = 1'b1; clks(Q);
    m_low = 1'b0; clks(2);
    m_low = 1'b1; clks(Q);
    chk("t5_glitch_stop_state", dbg_state, ST_SUB);
    m_scl = 1'b0; clks(Q);
    bus_stop(); clks(10);

    // async reset while the DUT drives the address ACK
    bus_start();
    send_bits(8'h78);
    m_low = 1'b0; clks(Q);
    m_scl = 1'b1; clks(Q);
    chk("t6_ack_driven", sda, 0);
    #3 rst = 1'b1;
    #1;
    chk("t6_sda_released", sda, 1);
    chk("t6_state", dbg_state, ST_IDLE);
    chk("t6_busy", busy, 0);
    chk("t6_addr", reg_addr, 0);
    chk("t6_wdata", reg_wdata, 0);
    chk("t6_we", reg_we, 0);
    chk("t6_re", reg_re, 0);
    m_scl = 1'b1;
    clks(5);
    rst = 1'b0;
    clks(10);

    // bus usable after reset
    we_q.push_back({8'h05, 8'h5A});
    bus_start();
    m_wr(8'h78, a); chk("t7_addr_ack", a, I2C_ACK);
    m_wr(8'h05, a); chk("t7_sub_ack", a, I2C_ACK);
    m_wr(8'h5A, a); chk("t7_data_ack", a, I2C_ACK);
    bus_stop(); clks(20);

    chk("we_q_drained", we_q.size(), 0);
    chk("re_q_drained", re_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
